// File: rtl/arith_pkg.sv
// Shared arithmetic constants and a reference subtraction model for the
// combinational/arithmetic leaf library.
package arith_pkg;

   localparam int DEFAULT_WIDTH = 1;
   localparam int MAX_WIDTH     = 64;

   // Returns {bout, d} in the low width+1 bits.
   // The caller must zero-extend a/b beyond width.
   function automatic logic [MAX_WIDTH:0] sub_ref(
      input logic [MAX_WIDTH-1:0] a,
      input logic [MAX_WIDTH-1:0] b,
      input logic                 bin,
      input int                   width
   );
      logic [MAX_WIDTH:0] diff;
      logic [MAX_WIDTH:0] mask;
      diff = {1'b0, a} - {1'b0, b} - {{MAX_WIDTH{1'b0}}, bin};
      mask = ({{MAX_WIDTH{1'b0}}, 1'b1} << (width + 1)) - 1'b1;
      return diff & mask;
   endfunction

endpackage

// File: rtl/full_subtractor_if.sv
// Operand/result bundle for full_subtractor.
// The master presents operands, and the slave (the subtractor) returns the difference.
interface full_subtractor_if
   import arith_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);
   logic             in_valid;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             Bin;
   logic [WIDTH-1:0] D;
   logic             Bout;
   logic             out_valid;

   modport master (
      output in_valid, a, b, Bin,
      input  D, Bout, out_valid
   );

   modport slave (
      input  in_valid, a, b, Bin,
      output D, Bout, out_valid
   );
endinterface

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor cell. Borrow-in comes from the next lower bit,
// and borrow-out goes to the next higher bit.
module full_subtractor_bit (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);
   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/full_subtractor.sv
// Width-parameterised ripple-borrow subtractor D = a - b - Bin.
// An optional output register stage carries valid alongside the result.
module full_subtractor
   import arith_pkg::*;
#(
   parameter int WIDTH   = DEFAULT_WIDTH,
   parameter bit REG_OUT = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   full_subtractor_if.slave  bus
);

   logic [WIDTH:0]   borrow;
   logic [WIDTH-1:0] diff;

   assign borrow[0] = bus.Bin;

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
         full_subtractor_bit u_bit (
            .a    (bus.a[gi]),
            .b    (bus.b[gi]),
            .bin  (borrow[gi]),
            .d    (diff[gi]),
            .bout (borrow[gi+1])
         );
      end

      if (REG_OUT) begin : g_reg
         logic [WIDTH-1:0] d_reg;
         logic             bout_reg;
         logic             valid_reg;

         // Capture every cycle. Valid only qualifies the result for consumers.
         always_ff @(posedge clk) begin
            if (rst) begin
               d_reg     <= '0;
               bout_reg  <= 1'b0;
               valid_reg <= 1'b0;
            end else begin
               d_reg     <= diff;
               bout_reg  <= borrow[WIDTH];
               valid_reg <= bus.in_valid;
            end
         end

         assign bus.D         = d_reg;
         assign bus.Bout      = bout_reg;
         assign bus.out_valid = valid_reg;
      end else begin : g_comb
         // The combinational variant is unclocked, so clk and rst are intentionally unused.
         logic unused_clk_rst;
         assign unused_clk_rst = clk ^ rst;

         assign bus.D         = diff;
         assign bus.Bout      = borrow[WIDTH];
         assign bus.out_valid = bus.in_valid;
      end
   endgenerate

endmodule

// File: tb/tb_full_subtractor.sv
// Bench for full_subtractor. It uses a scoreboard for the registered variants
// and direct combinational checks for REG_OUT=0.
module tb_full_subtractor;
   import arith_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   full_subtractor_if #(.WIDTH(1)) if1 ();
   full_subtractor_if #(.WIDTH(8)) if8 ();
   full_subtractor_if #(.WIDTH(1)) if0 ();

   full_subtractor #(.WIDTH(1), .REG_OUT(1'b1)) u_w1 (.clk(clk), .rst(rst), .bus(if1.slave));
   full_subtractor #(.WIDTH(8), .REG_OUT(1'b1)) u_w8 (.clk(clk), .rst(rst), .bus(if8.slave));
   full_subtractor #(.WIDTH(1), .REG_OUT(1'b0)) u_c1 (.clk(clk), .rst(rst), .bus(if0.slave));

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [7:0] d;
      logic       bout;
      logic       valid;
   } exp_t;

   typedef struct packed {
      logic a, b, bin, d, bout;
   } vec1_t;

   typedef struct packed {
      logic [7:0] a, b;
      logic       bin;
      logic [7:0] d;
      logic       bout;
   } vec8_t;

   exp_t q1[$];
   exp_t q8[$];
   exp_t e1, e8;
   vec1_t tab1[8];
   vec8_t tab8[4];

   function automatic exp_t model(logic [7:0] a, logic [7:0] b, logic bin,
                                  logic v, logic r, int w);
      logic [MAX_WIDTH:0] res;
      exp_t e;
      res    = sub_ref({56'b0, a}, {56'b0, b}, bin, w);
      e.d    = res[7:0] & 8'((1 << w) - 1);
      e.bout = res[w];
      e.valid = v;
      if (r) e = '0;
      return e;
   endfunction

   task automatic drive1(input logic a, input logic b, input logic bin,
                         input logic v, input logic r, input exp_t e);
      @(negedge clk);
      rst = r; if1.in_valid = v; if1.a = a; if1.b = b; if1.Bin = bin;
      q1.push_back(e);
   endtask

   task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                         input logic v, input exp_t e);
      @(negedge clk);
      rst = 1'b0; if8.in_valid = v; if8.a = a; if8.b = b; if8.Bin = bin;
      q8.push_back(e);
   endtask

   // Scoreboard: one expected entry per driven cycle, retired after the next edge
   always @(posedge clk) begin
      #1;
      if (q1.size() > 0) begin
         e1 = q1.pop_front();
         checks++;
         if ({7'b0, if1.D} !== e1.d || if1.Bout !== e1.bout || if1.out_valid !== e1.valid) begin
            errors++;
            $display("FAIL w1_reg t=%0t: got D=%0h Bout=%0b valid=%0b, want D=%0h Bout=%0b valid=%0b",
                     $time, if1.D, if1.Bout, if1.out_valid, e1.d, e1.bout, e1.valid);
         end
      end
      if (q8.size() > 0) begin
         e8 = q8.pop_front();
         checks++;
         if (if8.D !== e8.d || if8.Bout !== e8.bout || if8.out_valid !== e8.valid) begin
            errors++;
            $display("FAIL w8_reg t=%0t: got D=%0h Bout=%0b valid=%0b, want D=%0h Bout=%0b valid=%0b",
                     $time, if8.D, if8.Bout, if8.out_valid, e8.d, e8.bout, e8.valid);
         end
      end
   end

   initial begin
      // a, b, bin -> d, bout
      tab1[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tab1[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      tab1[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      tab1[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      tab1[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      tab1[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      tab1[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      tab1[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      tab8[0] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
      tab8[1] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0};
      tab8[2] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1};
      tab8[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0};

      if1.in_valid = 0; if1.a = 0; if1.b = 0; if1.Bin = 0;
      if8.in_valid = 0; if8.a = 0; if8.b = 0; if8.Bin = 0;
      if0.in_valid = 0; if0.a = 0; if0.b = 0; if0.Bin = 0;

      // Reset held for two cycles with live operands, then released
      drive1(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, '0);
      drive1(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, '0);
      drive1(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '{8'h01, 1'b0, 1'b1});

      // Exhaustive 1-bit table, one vector per cycle
      for (int i = 0; i < 8; i++)
         drive1(tab1[i].a, tab1[i].b, tab1[i].bin, 1'b1, 1'b0,
                '{{7'b0, tab1[i].d}, tab1[i].bout, 1'b1});

      // Mid-stream reset drops the operation presented in that cycle
      drive1(tab1[1].a, tab1[1].b, tab1[1].bin, 1'b1, 1'b0, '{{7'b0, tab1[1].d}, tab1[1].bout, 1'b1});
      drive1(tab1[4].a, tab1[4].b, tab1[4].bin, 1'b1, 1'b1, '0);
      drive1(tab1[7].a, tab1[7].b, tab1[7].bin, 1'b1, 1'b0, '{{7'b0, tab1[7].d}, tab1[7].bout, 1'b1});
      drive1(tab1[3].a, tab1[3].b, tab1[3].bin, 1'b1, 1'b0, '{{7'b0, tab1[3].d}, tab1[3].bout, 1'b1});
      // Invalid cycle still captures a deterministic result
      drive1(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '{8'h01, 1'b0, 1'b0});

      // 8-bit boundary vectors
      for (int i = 0; i < 4; i++)
         drive8(tab8[i].a, tab8[i].b, tab8[i].bin, 1'b1, '{tab8[i].d, tab8[i].bout, 1'b1});

      // 8-bit random stream checked against the reference model
      for (int i = 0; i < 10000; i++) begin
         logic [7:0] ra, rb;
         logic       rbin, rv;
         ra   = 8'($urandom);
         rb   = 8'($urandom);
         rbin = 1'($urandom_range(0, 1));
         rv   = 1'($urandom_range(0, 1));
         drive8(ra, rb, rbin, rv, model(ra, rb, rbin, rv, 1'b0, 8));
      end

      @(posedge clk);
      #3;
      checks++;
      if (q1.size() != 0 || q8.size() != 0) begin
         errors++;
         $display("FAIL drain: got q1=%0d q8=%0d pending, want 0 0", q1.size(), q8.size());
      end

      // Combinational variant: the result follows the inputs, and reset has no effect
      for (int i = 0; i < 8; i++) begin
         rst = (i == 5);
         if0.a = tab1[i].a; if0.b = tab1[i].b; if0.Bin = tab1[i].bin;
         if0.in_valid = (i != 2);
         #1;
         checks++;
         if (if0.D !== tab1[i].d || if0.Bout !== tab1[i].bout || if0.out_valid !== (i != 2)) begin
            errors++;
            $display("FAIL w1_comb vec%0d: got D=%0b Bout=%0b valid=%0b, want D=%0b Bout=%0b valid=%0b",
                     i, if0.D, if0.Bout, if0.out_valid, tab1[i].d, tab1[i].bout, (i != 2));
         end
      end
      rst = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
